// File: rtl/neuraedge_noc_pkg.sv
// Shared NoC definitions: flit tail marker position, egress arbiter state encoding
// and the default watchdog limit.
package neuraedge_noc_pkg;

    localparam int DEFAULT_FLIT_W      = 64;
    localparam int TAIL_BIT            = DEFAULT_FLIT_W - 1;
    localparam int DEFAULT_TIMEOUT_CYC = 256;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Tail marker always sits in the MSB, whatever the configured flit width.
    function automatic int tail_bit_of(input int flit_w);
        return flit_w - 1;
    endfunction

endpackage

// File: rtl/noc_ext_egress_arbiter_picker.sv
// Combinational round-robin picker: first request scanning upward from ptr+1, wrapping.
// Shared with the tile ingress scheduler.
module rr_priority_picker #(
    parameter int NUM_SRC = 16,
    parameter int IDX_W   = 4
)(
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_grant,
    output logic               o_any
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_SRC) begin
            sum = sum - NUM_SRC;
        end
        return IDX_W'(sum);
    endfunction

    assign o_any = |i_req;

    // Scan from the farthest offset down so the nearest requester after ptr wins last.
    always_comb begin
        o_grant = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            if (i_req[wrap_idx(i_ptr, k)]) begin
                o_grant = wrap_idx(i_ptr, k);
            end
        end
    end

endmodule

// File: rtl/noc_ext_egress_arbiter.sv
// Packet-locked round-robin arbiter feeding the external egress port via a one-entry output register.
// Optional watchdog on a stalled granted source: define NOC_ARB_WATCHDOG_EN.
module noc_ext_egress_arbiter
    import neuraedge_noc_pkg::*;
#(
    parameter int NUM_SRC     = 16,
    parameter int FLIT_W      = 64,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
)(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC*FLIT_W-1:0]  src_flit,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [NUM_SRC-1:0]         src_ready,
    output logic [FLIT_W-1:0]          ext_flit_out,
    output logic                       ext_valid_out,
    input  logic                       ext_ready_in,
    output logic                       busy,
    output logic [$clog2(NUM_SRC)-1:0] grant_id
`ifdef NOC_ARB_WATCHDOG_EN
    ,
    output logic                       timeout_err
`endif
);

    localparam int GW     = $clog2(NUM_SRC);
    localparam int W_TAIL = tail_bit_of(FLIT_W);

    if (TIMEOUT_CYC < 1 || NUM_SRC < 2) begin : g_bad_params
        $error("noc_ext_egress_arbiter: NUM_SRC must be >= 2 and TIMEOUT_CYC >= 1");
    end

    arb_state_t        r_state;
    logic [GW-1:0]     r_rr_ptr;
    logic [GW-1:0]     r_grant_id;
    logic [FLIT_W-1:0] r_out_flit;
    logic              r_out_vld;

    logic [FLIT_W-1:0] w_flits [NUM_SRC];
    logic [FLIT_W-1:0] w_flit_g;
    logic [GW-1:0]     w_pick;
    logic              w_any_req;
    logic              w_vld_g;
    logic              w_rdy_g;
    logic              w_xfer;
    logic              w_tail;
    logic              w_wd_fire;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            w_flits[i] = src_flit[i*FLIT_W +: FLIT_W];
        end
    end

    rr_priority_picker #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (GW)
    ) u_picker (
        .i_req   (src_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick),
        .o_any   (w_any_req)
    );

    // The output register can take a flit when empty or draining this cycle.
    assign w_flit_g = w_flits[r_grant_id];
    assign w_vld_g  = src_valid[r_grant_id];
    assign w_rdy_g  = !r_out_vld || ext_ready_in;
    assign w_xfer   = (r_state == LOCK) && w_vld_g && w_rdy_g;
    assign w_tail   = w_flit_g[W_TAIL];

    always_comb begin
        src_ready = '0;
        if (r_state == LOCK) begin
            src_ready[r_grant_id] = w_rdy_g;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rr_ptr   <= GW'(NUM_SRC - 1);
            r_grant_id <= '0;
            r_out_flit <= '0;
            r_out_vld  <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_out_flit <= w_flit_g;
                r_out_vld  <= 1'b1;
            end else if (ext_ready_in) begin
                r_out_vld  <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant_id <= w_pick;
                        r_state    <= LOCK;
                    end
                end
                LOCK: begin
                    if ((w_xfer && w_tail) || w_wd_fire) begin
                        r_rr_ptr <= r_grant_id;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef NOC_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout_err;

    // Only cycles where the granted source has nothing to offer count; egress backpressure does not.
    assign w_wd_fire = (r_state == LOCK) && !w_vld_g && (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else if (r_state != LOCK || w_xfer) begin
            r_wd_cnt      <= '0;
        end else if (!w_vld_g) begin
            if (w_wd_fire) begin
                r_wd_cnt      <= '0;
                r_timeout_err <= 1'b1;
            end else begin
                r_wd_cnt      <= r_wd_cnt + 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_wd_fire = 1'b0;
`endif

    assign ext_flit_out  = r_out_flit;
    assign ext_valid_out = r_out_vld;
    assign busy          = (r_state == LOCK);
    assign grant_id      = r_grant_id;

endmodule

// File: tb/tb_noc_ext_egress_arbiter.sv
// Directed scoreboard bench for noc_ext_egress_arbiter: expected egress flits are queued
// as packets are offered and popped as the egress port drains them.
module tb_noc_ext_egress_arbiter;

    localparam int NUM_SRC     = 16;
    localparam int FLIT_W      = 64;
    localparam int GW          = 4;
    localparam int TIMEOUT_CYC = 8;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_SRC*FLIT_W-1:0] src_flit;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [FLIT_W-1:0]         ext_flit_out;
    logic                      ext_valid_out;
    logic                      ext_ready_in;
    logic                      busy;
    logic [GW-1:0]             grant_id;
`ifdef NOC_ARB_WATCHDOG_EN
    logic                      timeout_err;
`endif

    noc_ext_egress_arbiter #(
        .NUM_SRC     (NUM_SRC),
        .FLIT_W      (FLIT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .src_flit      (src_flit),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .ext_flit_out  (ext_flit_out),
        .ext_valid_out (ext_valid_out),
        .ext_ready_in  (ext_ready_in),
        .busy          (busy),
        .grant_id      (grant_id)
`ifdef NOC_ARB_WATCHDOG_EN
        ,
        .timeout_err   (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    logic [FLIT_W-1:0]  srcq [NUM_SRC][$];
    logic [FLIT_W-1:0]  scb [$];
    int                 eg_cyc [$];
    logic [NUM_SRC-1:0] en;
    logic               rdy;
    logic               rst_v;
    int                 ncyc;
    int                 nchk;
    int                 nerr;

    function automatic logic [FLIT_W-1:0] mkflit(input int src, input int seq, input bit tail);
        return {tail, 15'h0, 8'(src), 8'hA5, 32'(seq)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_src(input int src, input int len, input int base);
        for (int k = 0; k < len; k++) begin
            srcq[src].push_back(mkflit(src, base + k, k == len - 1));
        end
    endtask

    task automatic expect_pkt(input int src, input int len, input int base);
        for (int k = 0; k < len; k++) begin
            scb.push_back(mkflit(src, base + k, k == len - 1));
        end
    endtask

    task automatic send_pkt(input int src, input int len, input int base);
        push_src(src, len, base);
        expect_pkt(src, len, base);
    endtask

    task automatic drive();
        rst_n        = rst_v;
        ext_ready_in = rdy;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_valid[i] = en[i] && (srcq[i].size() != 0);
            src_flit[i*FLIT_W +: FLIT_W] = (srcq[i].size() != 0) ? srcq[i][0] : '0;
        end
    endtask

    // Handshakes observed here complete at the next rising edge.
    task automatic monitor();
        logic [FLIT_W-1:0] exp;
        ncyc++;
        if (rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_valid[i] && src_ready[i]) begin
                    void'(srcq[i].pop_front());
                end
            end
            if (ext_valid_out && ext_ready_in) begin
                eg_cyc.push_back(ncyc);
                nchk++;
                assert (scb.size() != 0) else begin
                    nerr++;
                    $error("FAIL egress_extra: observed flit %h, expected no egress", ext_flit_out);
                end
                if (scb.size() != 0) begin
                    exp = scb.pop_front();
                    check("egress_flit", ext_flit_out, exp);
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #1;
        monitor();
    endtask

    task automatic run_until_empty(input string tag, input int budget);
        int n;
        n = 0;
        while ((scb.size() != 0 || ext_valid_out) && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_scb_empty"}, 64'(scb.size()), 64'd0);
        check({tag, "_out_idle"}, 64'(ext_valid_out), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int t0;
        nchk = 0;
        nerr = 0;
        ncyc = 0;
        en = '1;
        rdy = 1'b1;
        rst_v = 1'b0;
        rst_n = 1'b0;
        src_valid = '0;
        src_flit = '0;
        ext_ready_in = 1'b0;

        // Reset values
        repeat (2) cycle();
        check("rst_src_ready", 64'(src_ready), 64'd0);
        check("rst_valid", 64'(ext_valid_out), 64'd0);
        check("rst_flit", ext_flit_out, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
`ifdef NOC_ARB_WATCHDOG_EN
        check("rst_timeout", 64'(timeout_err), 64'd0);
`endif

        // Two-flit packet from source 0: arbitration, then first output two cycles later
        rst_v = 1'b1;
        eg_cyc.delete();
        send_pkt(0, 2, 1);
        cycle();
        t0 = ncyc;
        check("t1_arb_ready", 64'(src_ready), 64'd0);
        check("t1_arb_busy", 64'(busy), 64'd0);
        cycle();
        check("t1_grant", 64'(grant_id), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_ready", 64'(src_ready), 64'h0001);
        check("t1_no_out_yet", 64'(ext_valid_out), 64'd0);
        cycle();
        check("t1_valid_head", 64'(ext_valid_out), 64'd1);
        cycle();
        check("t1_busy_after_tail", 64'(busy), 64'd0);
        check("t1_valid_tail", 64'(ext_valid_out), 64'd1);
        cycle();
        check("t1_valid_cleared", 64'(ext_valid_out), 64'd0);
        check("t1_egress_count", 64'(eg_cyc.size()), 64'd2);
        if (eg_cyc.size() == 2) begin
            check("t1_first_latency", 64'(eg_cyc[0] - t0), 64'd2);
            check("t1_back_to_back", 64'(eg_cyc[1] - eg_cyc[0]), 64'd1);
        end

        // Sources 2, 5, 9 with continuous 3-flit packets, two rounds
        eg_cyc.delete();
        send_pkt(2, 3, 10);
        send_pkt(5, 3, 20);
        send_pkt(9, 3, 30);
        send_pkt(2, 3, 40);
        send_pkt(5, 3, 50);
        send_pkt(9, 3, 60);
        run_until_empty("t2", 60);
        check("t2_egress_count", 64'(eg_cyc.size()), 64'd18);
        if (eg_cyc.size() == 18) begin
            check("t2_in_packet", 64'(eg_cyc[2] - eg_cyc[0]), 64'd2);
            check("t2_gap", 64'(eg_cyc[3] - eg_cyc[2]), 64'd2);
            check("t2_span", 64'(eg_cyc[17] - eg_cyc[0]), 64'd22);
        end

        // Only source 15, single-flit packets: wrap-around grant, one flit every 2 cycles
        eg_cyc.delete();
        for (int k = 0; k < 3; k++) begin
            send_pkt(15, 1, 100 + k);
        end
        cycle();
        cycle();
        check("t4_grant", 64'(grant_id), 64'd15);
        run_until_empty("t4", 30);
        check("t4_egress_count", 64'(eg_cyc.size()), 64'd3);
        if (eg_cyc.size() == 3) begin
            check("t4_spacing", 64'(eg_cyc[1] - eg_cyc[0]), 64'd2);
            check("t4_span", 64'(eg_cyc[2] - eg_cyc[0]), 64'd4);
        end

        // Egress stall for 5 cycles mid-packet on source 7
        send_pkt(7, 4, 70);
        cycle();
        cycle();
        cycle();
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("t3_stall_ready", 64'(src_ready), 64'd0);
            check("t3_hold_valid", 64'(ext_valid_out), 64'd1);
            check("t3_hold_flit", ext_flit_out, mkflit(7, 71, 1'b0));
        end
        rdy = 1'b1;
        run_until_empty("t3", 30);
        check("t3_src_drained", 64'(srcq[7].size()), 64'd0);

        // Reset during the second flit of a 4-flit packet from source 10
        push_src(10, 4, 200);
        cycle();
        cycle();
        check("t5_grant_before", 64'(grant_id), 64'd10);
        push_src(3, 2, 300);
        push_src(12, 2, 310);
        rst_v = 1'b0;
        cycle();
        rst_v = 1'b1;
        srcq[10].delete();
        scb.delete();
        expect_pkt(3, 2, 300);
        expect_pkt(12, 2, 310);
        cycle();
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_valid", 64'(ext_valid_out), 64'd0);
        check("t5_rst_flit", ext_flit_out, 64'd0);
        check("t5_rst_grant", 64'(grant_id), 64'd0);
        check("t5_rst_ready", 64'(src_ready), 64'd0);
        cycle();
        check("t5_lowest_grant", 64'(grant_id), 64'd3);
        check("t5_busy", 64'(busy), 64'd1);
        run_until_empty("t5", 30);

`ifdef NOC_ARB_WATCHDOG_EN
        // Source 3 stalls after its head; source 4 waits behind it
        send_pkt(3, 2, 400);
        send_pkt(4, 1, 410);
        scb.delete();
        expect_pkt(3, 1, 400);
        expect_pkt(4, 1, 410);
        cycle();
        cycle();
        check("wd_grant3", 64'(grant_id), 64'd3);
        en[3] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle();
        end
        check("wd_not_yet", 64'(timeout_err), 64'd0);
        cycle();
        check("wd_fired", 64'(timeout_err), 64'd1);
        check("wd_idle", 64'(busy), 64'd0);
        cycle();
        check("wd_next_grant", 64'(grant_id), 64'd4);
        run_until_empty("wd", 30);
        srcq[3].delete();
        en[3] = 1'b1;
        check("wd_sticky", 64'(timeout_err), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
